wb_stage_q: RTL and testbench

- Registered, parametrised writeback stage for the RISC pipeline; replaces the purely combinational writeback mux.
- Selects ALU or load data for the register file and registers the write, with one cycle of latency.
- Exposes a forwarding tap for the hazard unit.
- Buffers OUT-instruction (port write) data in a small FIFO drained by a valid/ready handshake to the output peripheral.
- Back-pressures the pipeline when that FIFO is full.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_stage_q_if.sv | 55 +++++
 rtl/wb_port_fifo.sv | 82 ++++++++
 rtl/wb_stage_q.sv | 94 +++++++++
 tb/tb_wb_stage_q.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared constants and helpers for the registered writeback stage.
package wb_pkg;

  // Default datapath and register-file address widths.
  localparam int DATA_W_DEF     = 16;
  localparam int ADDR_W_DEF     = 3;
  localparam int PORT_DEPTH_DEF = 4;

  // Writeback source select encoding.
  localparam logic WB_SEL_ALU  = 1'b0;
  localparam logic WB_SEL_LOAD = 1'b1;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Width of a read/write pointer into a power-of-two deep buffer.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wb_stage_q_if.sv
// Bundle of the writeback stage's pipeline, register-file, forwarding and
// output-port signals. The slave modport is the stage's view; the master
// modport is the view of whatever surrounds it (pipeline + peripheral).
interface wb_stage_q_if
  import wb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int PORT_DEPTH = PORT_DEPTH_DEF
);
  localparam int CNT_W = cnt_w(PORT_DEPTH);

  // MEM/WB input handshake and payload
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_alu_data;
  logic [DATA_W-1:0] in_load_data;
  logic              in_wb_sel;
  logic              in_reg_write;
  logic [ADDR_W-1:0] in_dest;
  logic              in_port_write;

  // Register-file write port
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  // Forwarding tap for the hazard unit
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;

  // Output-port stream
  logic              port_valid;
  logic [DATA_W-1:0] port_data;
  logic              port_ready;
  logic [CNT_W-1:0]  port_count;

  modport slave (
    input  in_valid, in_alu_data, in_load_data, in_wb_sel,
           in_reg_write, in_dest, in_port_write, port_ready,
    output in_ready, rf_we, rf_waddr, rf_wdata,
           fwd_valid, fwd_addr, fwd_data,
           port_valid, port_data, port_count
  );

  modport master (
    output in_valid, in_alu_data, in_load_data, in_wb_sel,
           in_reg_write, in_dest, in_port_write, port_ready,
    input  in_ready, rf_we, rf_waddr, rf_wdata,
           fwd_valid, fwd_addr, fwd_data,
           port_valid, port_data, port_count
  );

endinterface

// File: rtl/wb_port_fifo.sv
// Small circular FIFO buffering OUT-instruction data for the output port.
// No fall-through: a pushed word becomes visible at the head one cycle later.
// The head reads as zero while the buffer is empty so the port data is a
// well-defined value after reset. PORT_DEPTH must be a power of two >= 2 so
// the pointers wrap by simple overflow.
module wb_port_fifo
  import wb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PORT_DEPTH = PORT_DEPTH_DEF,
  localparam int CNT_W     = cnt_w(PORT_DEPTH),
  localparam int PTR_W     = ptr_w(PORT_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o
);

  logic [DATA_W-1:0] mem_q [PORT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              empty;
  logic              push_ok;
  logic              pop_ok;

  assign empty  = (count_q == '0);
  assign full_o = (count_q == CNT_W'(PORT_DEPTH));

  // Ignore a push into a full buffer or a pop from an empty one so the
  // occupancy can never leave 0..PORT_DEPTH even if a caller misbehaves.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i  & ~empty;

  assign count_o = count_q;
  assign head_o  = empty ? '0 : mem_q[rd_ptr_q];

  // Storage write at the tail; the array has no reset since occupancy
  // alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Next pointers and occupancy from the qualified push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the buffer immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wb_stage_q.sv
// Registered writeback stage: muxes ALU/load data into a one-cycle-latency
// register-file write, mirrors that write onto a forwarding tap, and queues
// OUT-instruction data for the output peripheral. The stage stalls the
// pipeline only when the port buffer is full; in_ready depends solely on
// registered occupancy so it never forms a combinational path from the
// peripheral's port_ready or from the incoming instruction.
module wb_stage_q
  import wb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int PORT_DEPTH = PORT_DEPTH_DEF,
  localparam int CNT_W     = cnt_w(PORT_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_stage_q_if.slave   bus
);

  logic              accept;
  logic              push;
  logic              pop;
  logic              full;
  logic              port_valid;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] wb_data;

  logic              rf_we_q,    rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  // Handshake glue
  assign bus.in_ready = ~full;
  assign accept       = bus.in_valid & ~full;
  assign push         = accept & bus.in_port_write;
  assign port_valid   = (count != '0);
  assign pop          = port_valid & bus.port_ready;

  // Output-port buffer
  wb_port_fifo #(
    .DATA_W     (DATA_W),
    .PORT_DEPTH (PORT_DEPTH)
  ) u_port_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (bus.in_load_data),
    .head_o  (head),
    .count_o (count),
    .full_o  (full)
  );

  assign bus.port_valid = port_valid;
  assign bus.port_data  = head;
  assign bus.port_count = count;

  // Writeback mux and next register-file write; a port write never touches
  // the register file, and address/data hold unless a new write happens.
  always_comb begin
    wb_data    = (bus.in_wb_sel == WB_SEL_LOAD) ? bus.in_load_data : bus.in_alu_data;
    rf_we_d    = accept & bus.in_reg_write & ~bus.in_port_write;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (rf_we_d) begin
      rf_waddr_d = bus.in_dest;
      rf_wdata_d = wb_data;
    end
  end

  // Register-file write registers; reset drops any pending write at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;

  // The forwarding tap is the same flops as the register-file write.
  assign bus.fwd_valid = rf_we_q;
  assign bus.fwd_addr  = rf_waddr_q;
  assign bus.fwd_data  = rf_wdata_q;

endmodule

// File: tb/tb_wb_stage_q.sv
// Scoreboard bench for wb_stage_q: a model of the stage's rules predicts the
// register-file writes and the output-port stream; a monitor compares on the
// falling edge.
module tb_wb_stage_q;
  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } rf_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  rf_t           rf_q[$];
  logic [DW-1:0] port_q[$];
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_data = '0;

  wb_stage_q_if #(.DATA_W(DW), .ADDR_W(AW), .PORT_DEPTH(DEPTH)) bus();

  wb_stage_q #(.DATA_W(DW), .ADDR_W(AW), .PORT_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: acceptance, port buffer order and register writes.
  always @(posedge clk) begin
    bit acc;
    bit pp;
    if (rst_n) begin
      acc = bus.in_valid && (port_q.size() < DEPTH);
      pp  = (port_q.size() != 0) && bus.port_ready;
      if (pp) void'(port_q.pop_front());
      if (acc && bus.in_port_write) port_q.push_back(bus.in_load_data);
      if (acc && bus.in_reg_write && !bus.in_port_write)
        rf_q.push_back('{bus.in_dest, bus.in_wb_sel ? bus.in_load_data : bus.in_alu_data});
    end
  end

  // Reset discards everything the model holds.
  always @(negedge rst_n) begin
    port_q.delete();
    rf_q.delete();
    last_addr = '0;
    last_data = '0;
  end

  // Monitor: compare DUT outputs against the model once per cycle.
  always @(negedge clk) begin
    logic          exp_we;
    logic [DW-1:0] exp_pd;
    rf_t           e;
    exp_we = (rf_q.size() != 0);
    if (exp_we) begin
      e = rf_q.pop_front();
      last_addr = e.addr;
      last_data = e.data;
      $display("rf write addr=%0d data=%h", e.addr, e.data);
    end
    chk("rf_we",      32'(bus.rf_we),     32'(exp_we));
    chk("fwd_valid",  32'(bus.fwd_valid), 32'(exp_we));
    chk("rf_waddr",   32'(bus.rf_waddr),  32'(last_addr));
    chk("rf_wdata",   32'(bus.rf_wdata),  32'(last_data));
    chk("fwd_addr",   32'(bus.fwd_addr),  32'(last_addr));
    chk("fwd_data",   32'(bus.fwd_data),  32'(last_data));
    exp_pd = (port_q.size() != 0) ? port_q[0] : '0;
    chk("port_count", 32'(bus.port_count), 32'(port_q.size()));
    chk("port_valid", 32'(bus.port_valid), 32'(port_q.size() != 0));
    chk("port_data",  32'(bus.port_data),  32'(exp_pd));
    chk("in_ready",   32'(bus.in_ready),   32'(port_q.size() < DEPTH));
    if (rst_n && bus.port_valid && bus.port_ready)
      $display("port out data=%h", bus.port_data);
  end

  function automatic logic drive_ready(input int rmode);
    if (rmode == 2) return logic'($urandom_range(0, 1));
    return (rmode == 1);
  endfunction

  // Present one instruction, holding it until the stage accepts it.
  task automatic issue(input logic sel, input logic [DW-1:0] alu, input logic [DW-1:0] load,
                       input logic rw, input logic [AW-1:0] dest, input logic pw, input int rmode);
    int n = 0;
    bit done = 0;
    while (!done) begin
      @(negedge clk);
      bus.in_valid      = 1'b1;
      bus.in_wb_sel     = sel;
      bus.in_alu_data   = alu;
      bus.in_load_data  = load;
      bus.in_reg_write  = rw;
      bus.in_dest       = dest;
      bus.in_port_write = pw;
      bus.port_ready    = drive_ready(rmode);
      done = (port_q.size() < DEPTH);
      n++;
      if (!done && n > 50) begin
        n_chk++;
        n_fail++;
        $display("FAIL issue_timeout: got stalled expected accept within 50 cycles");
        done = 1;
      end
    end
  endtask

  // One cycle with no valid instruction; payload inputs are garbage.
  task automatic idle(input int rmode);
    @(negedge clk);
    bus.in_valid      = 1'b0;
    bus.in_wb_sel     = logic'($urandom_range(0, 1));
    bus.in_alu_data   = DW'($urandom);
    bus.in_load_data  = DW'($urandom);
    bus.in_reg_write  = logic'($urandom_range(0, 1));
    bus.in_dest       = AW'($urandom);
    bus.in_port_write = logic'($urandom_range(0, 1));
    bus.port_ready    = drive_ready(rmode);
  endtask

  task automatic drain();
    int n = 0;
    while (port_q.size() != 0 && n < 100) begin
      idle(1);
      n++;
    end
    idle(0);
    chk("drain_empty", 32'(port_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_wb_sel = 1'b0;
    bus.in_alu_data = '0;
    bus.in_load_data = '0;
    bus.in_reg_write = 1'b0;
    bus.in_dest = '0;
    bus.in_port_write = 1'b0;
    bus.port_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(0);

    // ALU and load writeback, then an OUT that must not write the RF
    issue(1'b0, 16'h1234, 16'hBEEF, 1'b1, 3'd3, 1'b0, 0);
    idle(0);
    idle(0);
    issue(1'b1, 16'h1234, 16'hBEEF, 1'b1, 3'd5, 1'b0, 0);
    idle(0);
    issue(1'b1, 16'h5555, 16'h00AA, 1'b1, 3'd6, 1'b1, 0);
    idle(0);
    idle(0);
    drain();

    // Fill to full, hold a fifth write, free one slot
    for (int i = 1; i <= 4; i++) issue(1'b0, '0, DW'(i), 1'b0, '0, 1'b1, 0);
    @(negedge clk);
    bus.in_load_data = 16'h0005;
    bus.port_ready = 1'b0;
    @(negedge clk);
    bus.port_ready = 1'b1;
    issue(1'b0, '0, 16'h0005, 1'b0, '0, 1'b1, 0);
    idle(0);
    drain();

    // Interleaved pushes/pops across the pointer wrap
    for (int i = 1; i <= 6; i++) begin
      issue(1'b0, '0, DW'(i), 1'b0, '0, 1'b1, i % 2);
      idle(2);
    end
    drain();

    // Simultaneous push and pop at occupancy 2
    issue(1'b0, '0, 16'h0010, 1'b0, '0, 1'b1, 0);
    issue(1'b0, '0, 16'h0011, 1'b0, '0, 1'b1, 0);
    issue(1'b0, '0, 16'h0012, 1'b0, '0, 1'b1, 1);
    idle(0);
    drain();

    // Reset in the middle of a burst with a pending RF write
    for (int i = 0; i < 3; i++) issue(1'b0, '0, DW'(16'h21 + i), 1'b0, '0, 1'b1, 0);
    issue(1'b0, 16'h0077, 16'h0000, 1'b1, 3'd2, 1'b0, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rf_we",      32'(bus.rf_we),      32'd0);
    chk("rst_port_valid", 32'(bus.port_valid), 32'd0);
    chk("rst_port_count", 32'(bus.port_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, '0, 16'h0031, 1'b0, '0, 1'b1, 1);
    issue(1'b0, '0, 16'h0032, 1'b0, '0, 1'b1, 1);
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.in_valid      = logic'($urandom_range(0, 1));
      bus.in_wb_sel     = logic'($urandom_range(0, 1));
      bus.in_alu_data   = DW'($urandom);
      bus.in_load_data  = DW'($urandom);
      bus.in_reg_write  = logic'($urandom_range(0, 1));
      bus.in_dest       = AW'($urandom);
      bus.in_port_write = logic'($urandom_range(0, 1));
      bus.port_ready    = (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
    end
    drain();
    idle(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
